// File: rtl/plab5_mcore_proc_sec_tracker.sv
// Tags each core memory request with the issuing security level and returns that level alongside the in-order response.
// Zero-cycle combinational pass-through on both request and response paths; state updates on the clock edge.
// Requests stall when p_max_outstanding are in flight; responses are held (never popped) while nothing is outstanding.
module plab5_mcore_proc_sec_tracker #(
   parameter  int p_opaque_nbits    = 8,
   parameter  int p_addr_nbits      = 32,
   parameter  int p_data_nbits      = 32,
   parameter  int p_max_outstanding = 4,
   localparam int len_nbits         = $clog2(p_data_nbits/8),
   localparam int req_nbits         = 3 + p_opaque_nbits + p_addr_nbits + len_nbits + p_data_nbits,
   localparam int resp_nbits        = 3 + p_opaque_nbits + 2 + len_nbits + p_data_nbits,
   localparam int cnt_nbits         = $clog2(p_max_outstanding + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  proc_sec_level,
   input  logic                  proc_req_val,
   output logic                  proc_req_rdy,
   input  logic [req_nbits-1:0]  proc_req_msg,
   output logic                  net_req_val,
   input  logic                  net_req_rdy,
   output logic [req_nbits-1:0]  net_req_msg,
   output logic                  net_req_sec_level,
   input  logic                  net_resp_val,
   output logic                  net_resp_rdy,
   input  logic [resp_nbits-1:0] net_resp_msg,
   output logic                  acc_resp_val,
   input  logic                  acc_resp_rdy,
   output logic [resp_nbits-1:0] acc_resp_msg,
   output logic                  resp_sec_level,
   output logic [cnt_nbits-1:0]  outstanding,
   output logic                  err_spurious
);

   localparam int ptr_nbits = $clog2(p_max_outstanding);
   localparam logic [ptr_nbits-1:0] last_idx = ptr_nbits'(p_max_outstanding - 1);

   logic [p_max_outstanding-1:0] level_q;
   logic [ptr_nbits-1:0]         wr_ptr;
   logic [ptr_nbits-1:0]         rd_ptr;
   logic [cnt_nbits-1:0]         count;

   logic full;
   logic empty;
   logic req_fire;
   logic resp_fire;

   assign full  = (count == cnt_nbits'(p_max_outstanding));
   assign empty = (count == '0);

   // Request path: full depends only on registered count, so no response->request path exists.
   assign net_req_val       = proc_req_val & ~full;
   assign proc_req_rdy      = net_req_rdy & ~full;
   assign net_req_msg       = proc_req_msg;
   assign net_req_sec_level = proc_sec_level;
   assign req_fire          = proc_req_val & proc_req_rdy;

   // Response path: with nothing tracked, hold the response and report the most restrictive level.
   assign acc_resp_val   = net_resp_val & ~empty;
   assign net_resp_rdy   = acc_resp_rdy & ~empty;
   assign acc_resp_msg   = net_resp_msg;
   assign resp_sec_level = empty ? 1'b1 : level_q[rd_ptr];
   assign resp_fire      = net_resp_val & net_resp_rdy;

   assign outstanding = count;

   // Level storage: captured at issue time, contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (req_fire) level_q[wr_ptr] <= proc_sec_level;
   end

   // Pointers, occupancy and sticky spurious-response flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (req_fire)  wr_ptr <= (wr_ptr == last_idx) ? '0 : wr_ptr + 1'b1;
         if (resp_fire) rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
         if (req_fire && !resp_fire)      count <= count + 1'b1;
         else if (!req_fire && resp_fire) count <= count - 1'b1;
         if (net_resp_val && empty) err_spurious <= 1'b1;
      end
   end

endmodule

// File: doc/plab5_mcore_proc_sec_tracker.md
Name: plab5_mcore_proc_sec_tracker

Overview:
- Sits between a core's memory port and the network, directly upstream of the processor response access-control stage.
- Stamps each outgoing request with the core's security level at issue time and records that level in an in-order tracking FIFO.
- Drives the head-of-FIFO level as resp_sec_level on the matching response, so the downstream access stage knows the level of the response it is filtering.
- Gives requests a bounded outstanding count.

Parameters:
- p_opaque_nbits, 8, mem message opaque field bits
- p_addr_nbits, 32, mem message address bits
- p_data_nbits, 32, mem message data bits
- p_max_outstanding, 4, tracking FIFO depth (power of two, >=2)
- req_nbits, VC_MEM_REQ_MSG_NBITS(o,a,d), derived, not set externally
- resp_nbits, VC_MEM_RESP_MSG_NBITS(o,d), derived, not set externally

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- proc_sec_level  in  1  current core security level
- proc_req_val  in  1  request valid from core
- proc_req_rdy  out  1  request ready to core
- proc_req_msg  in  req_nbits  request from core
- net_req_val  out  1  request valid to network
- net_req_rdy  in  1  network ready
- net_req_msg  out  req_nbits  request to network (equals proc_req_msg)
- net_req_sec_level  out  1  level tag travelling with request (equals proc_sec_level)
- net_resp_val  in  1  response valid from network
- net_resp_rdy  out  1  response ready to network
- net_resp_msg  in  resp_nbits  response from network
- acc_resp_val  out  1  response valid to access stage
- acc_resp_rdy  in  1  access stage ready
- acc_resp_msg  out  resp_nbits  response to access stage (equals net_resp_msg)
- resp_sec_level  out  1  level of response currently presented
- outstanding  out  clog2(p_max_outstanding+1)  registered count of in-flight requests
- err_spurious  out  1  sticky: response arrived with nothing outstanding

Behaviour:
- State: FIFO storage of p_max_outstanding 1-bit entries, wr_ptr, rd_ptr, count, err_spurious.
- full = (count == p_max_outstanding); empty = (count == 0).
- Request path is combinational, zero latency:
  - net_req_val = proc_req_val & !full
  - proc_req_rdy = net_req_rdy & !full
  - Ready must not depend on same-cycle response pop; no comb path response->request.
- Push: req_fire = proc_req_val & proc_req_rdy. On the rising edge, write proc_sec_level at wr_ptr and advance wr_ptr modulo depth.
- Response path is combinational, zero latency:
  - acc_resp_val = net_resp_val & !empty
  - net_resp_rdy = acc_resp_rdy & !empty
- resp_sec_level = FIFO[rd_ptr] when !empty; forced to 1 (most restrictive) when empty. It is never X.
- Pop: resp_fire = net_resp_val & net_resp_rdy. On the edge, advance rd_ptr modulo depth.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
- Pointer wrap: at index p_max_outstanding-1, the next index is 0.
- Responses are assumed in order; the FIFO head always belongs to the oldest outstanding request.
- proc_sec_level changing with requests outstanding:
  - existing entries keep their captured levels
  - only subsequent pushes use the new level
- Full: requests stall (proc_req_rdy=0) until a pop is registered. A simultaneous pop does not unstall that cycle.
- Empty with net_resp_val=1:
  - response held (net_resp_rdy=0, acc_resp_val=0)
  - err_spurious set on that edge and stays set until reset
- Reset (reset==0 at an edge), including mid-operation:
  - count, wr_ptr, rd_ptr, err_spurious all go to 0
  - in-flight entries discarded
  - resulting outputs: proc_req_rdy=net_req_rdy, net_resp_rdy=0, acc_resp_val=0, resp_sec_level=1, outstanding=0
- FIFO contents need no reset.

Test Plan:
- Reset with net_req_rdy=1, proc_sec_level=0 -> outstanding=0, resp_sec_level=1, acc_resp_val=0 even when net_resp_val=1, err_spurious=1 one edge later.
- Issue 3 requests with levels 0,1,0, then return 3 responses with acc_resp_rdy=1 -> resp_sec_level 0,1,0 on successive responses; outstanding 3->0.
- Issue 4 requests with no responses -> outstanding=4, proc_req_rdy=0, net_req_val=0 for a 5th request. Pop one (same cycle as the 5th request) -> the 5th request accepted only on the following cycle.
- Simultaneous push (level 1) and pop at outstanding=2, repeated 10 cycles -> outstanding stays 2. Pointers wrap and levels emerge in push order.
- acc_resp_rdy=0 for 5 cycles with a response pending -> net_resp_rdy=0, head level and count unchanged, no pop.
- Assert reset with 3 outstanding -> next cycle outstanding=0, err_spurious=0, and a following response is treated as spurious.
